fetch_sequencer: RTL
====================

Name: fetch_sequencer

Overview:
- Control FSM that sequences the 16-bit program counter register through fetch / increment / execute / branch.
- Drives the PC register's write, read and incpc strobes and its 16-bit write data.
- Runs a req/ack handshake with instruction memory, holds the fetched instruction in an internal instruction register, and hands off to the execute unit with a start/done handshake.

Parameters:
- DW, 16, width of PC, branch target and instruction.
- TIMEOUT, 16, number of REQ cycles without mem_ack before FAULT (watchdog build only); minimum 2.

Ports:
- clk  input  1  system clock; all state updates on posedge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  begin fetching from the current PC; sampled only in IDLE.
- halt_req  input  1  stop after the current instruction completes.
- mem_ack  input  1  instruction memory has valid data on instr_in; sampled only in REQ.
- instr_in  input  DW  instruction word from memory.
- exec_done  input  1  execute unit finished; sampled only in WAIT.
- branch_taken  input  1  qualifies exec_done; redirect the PC.
- branch_target  input  DW  new PC value, valid with exec_done.
- pc_read  output  1  PC register read strobe.
- pc_write  output  1  PC register load strobe.
- pc_incpc  output  1  PC register increment strobe.
- pc_data_in  output  DW  PC register load value.
- mem_req  output  1  instruction fetch request.
- ir_load  output  1  pulse: ir has just been updated.
- ir  output  DW  registered instruction.
- exec_start  output  1  one-cycle pulse to the execute unit.
- busy  output  1  high when state is neither IDLE nor FAULT.
- fault  output  1  fetch watchdog fault.
- state  output  3  current state encoding, for debug.

Behaviour:
- Interface: one clock, clk; reset rst is asynchronous and active-high.
- State encoding: IDLE=0, ADDR=1, REQ=2, INC=3, EXEC=4, WAIT=5, BRANCH=6, FAULT=7.
- Reset (asynchronous, any time, including mid-handshake):
  - state=IDLE.
  - ir=0, tgt=0, watchdog counter=0.
  - All strobes 0; fault=0; busy=0.
- Control strobes are Moore outputs decoded from the state register only:
  - pc_read=1 in ADDR (the PC register presents its address at the following negedge).
  - mem_req=1 in REQ.
  - pc_incpc=1 and ir_load=1 in INC.
  - exec_start=1 in EXEC.
  - pc_write=1 in BRANCH.
  - fault=1 in FAULT.
- pc_write and pc_incpc are never asserted in the same cycle.
- pc_data_in = tgt, an internal register; it drives 0 until the first branch.
- Transitions:
  - IDLE: start=1 -> ADDR; otherwise stay.
  - ADDR -> REQ, unconditionally.
  - REQ: mem_ack=1 -> INC, and ir<=instr_in on that same edge. Otherwise stay; mem_req is held high until ack.
  - INC -> EXEC.
  - EXEC -> WAIT.
  - WAIT, exec_done=0: stay.
  - WAIT, exec_done=1 & branch_taken=1: tgt<=branch_target -> BRANCH.
  - WAIT, exec_done=1 & branch_taken=0: halt_req=1 -> IDLE, else -> ADDR.
  - BRANCH: halt_req=1 -> IDLE, else -> ADDR.
  - FAULT: stay until rst.
- Latency:
  - start at edge 0 -> ADDR in cycle 1, REQ in cycle 2.
  - Zero-wait ack -> INC in cycle 3, EXEC in cycle 4, WAIT in cycle 5.
  - Minimum instruction period is 5 cycles without a branch, 6 with a branch.
- Ignored inputs:
  - start outside IDLE.
  - mem_ack outside REQ.
  - exec_done outside WAIT.
  - branch_taken without exec_done.
- halt_req is sampled only on the WAIT-exit or BRANCH edge. The in-flight instruction always completes, and a taken branch is still written to the PC before IDLE.

Optional Feature:
- Macro: FETCH_WATCHDOG_EN.
- Defined:
  - The counter clears on every entry to REQ and increments on each REQ cycle with mem_ack=0.
  - When the counter equals TIMEOUT-1 and mem_ack=0 -> FAULT.
  - mem_ack=1 in the timeout cycle wins: the FSM goes to INC.
  - In FAULT, fault=1 and all other strobes are 0 until rst.
- Undefined:
  - No counter; REQ waits indefinitely.
  - FAULT is unreachable and fault is tied 0.

Test Plan:
- Straight-line fetch: rst, then start=1 for 1 cycle. mem_ack returns 1 cycle after mem_req, with instr_in=16'hA5A5; exec_done arrives 2 cycles after exec_start.
  -> states 1,2,3,4,5 in order; ir=16'hA5A5 with ir_load in INC; exactly one pc_incpc per instruction; back in ADDR after exec_done.
- Branch: exec_done=1 with branch_taken=1 and branch_target=16'h0040.
  -> BRANCH for 1 cycle with pc_write=1, pc_data_in=16'h0040 and pc_incpc=0; then ADDR.
- Halt: halt_req=1 held during WAIT, then exec_done (non-branch).
  -> IDLE, busy=0, no further mem_req. Repeat with a taken branch: pc_write pulse, then IDLE.
- Memory stall: mem_ack delayed 9 cycles (watchdog build, TIMEOUT=16).
  -> mem_req high for 10 cycles, no FAULT. ir captures instr_in on the ack edge only; mem_ack pulses in other states are ignored.
- Watchdog (FETCH_WATCHDOG_EN, TIMEOUT=16): mem_ack never asserted.
  -> FAULT after exactly 16 REQ cycles; fault=1, state=7, all strobes 0. A case with ack exactly in cycle 16 goes to INC. Without the macro, REQ persists for over 100 cycles with fault=0.
- Reset mid-REQ and mid-WAIT: assert rst asynchronously between clock edges.
  -> state=0, ir=0, pc_data_in=0 and all strobes 0 immediately; start is ignored while rst=1.

Source files
------------

// File: rtl/fetch_sequencer.sv
// fetch_sequencer: control FSM sequencing the PC register through
// fetch / increment / execute / branch, with an instruction-memory req/ack
// handshake and an execute-unit start/done handshake.
// Optional build macro FETCH_WATCHDOG_EN adds a fetch watchdog that moves the
// FSM to FAULT after TIMEOUT REQ cycles without mem_ack; without it FAULT is
// unreachable and fault is tied low.
module fetch_sequencer #(
  parameter int unsigned DW      = 16,
  parameter int unsigned TIMEOUT = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          halt_req,
  input  logic          mem_ack,
  input  logic [DW-1:0] instr_in,
  input  logic          exec_done,
  input  logic          branch_taken,
  input  logic [DW-1:0] branch_target,
  output logic          pc_read,
  output logic          pc_write,
  output logic          pc_incpc,
  output logic [DW-1:0] pc_data_in,
  output logic          mem_req,
  output logic          ir_load,
  output logic [DW-1:0] ir,
  output logic          exec_start,
  output logic          busy,
  output logic          fault,
  output logic [2:0]    state
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_ADDR   = 3'd1,
    S_REQ    = 3'd2,
    S_INC    = 3'd3,
    S_EXEC   = 3'd4,
    S_WAIT   = 3'd5,
    S_BRANCH = 3'd6,
    S_FAULT  = 3'd7
  } state_t;

  state_t        state_q;
  state_t        nxt;
  logic [DW-1:0] tgt;
  logic          wd_expired;

  // A watchdog that fires on the first REQ cycle would make every fetch fault.
  if (TIMEOUT < 2) begin : g_timeout_check
    $error("fetch_sequencer: TIMEOUT must be at least 2");
  end

  assign state      = state_q;
  assign pc_data_in = tgt;

  // Next-state decode; ignored inputs simply do not appear in a state's arm.
  always_comb begin
    nxt = state_q;
    case (state_q)
      S_IDLE:   if (start) nxt = S_ADDR;
      S_ADDR:   nxt = S_REQ;
      S_REQ: begin
        if (mem_ack)         nxt = S_INC;
        else if (wd_expired) nxt = S_FAULT;
      end
      S_INC:    nxt = S_EXEC;
      S_EXEC:   nxt = S_WAIT;
      S_WAIT: begin
        if (exec_done) begin
          if (branch_taken)  nxt = S_BRANCH;
          else if (halt_req) nxt = S_IDLE;
          else               nxt = S_ADDR;
        end
      end
      S_BRANCH: nxt = halt_req ? S_IDLE : S_ADDR;
      S_FAULT:  nxt = S_FAULT;
      default:  nxt = S_IDLE;
    endcase
  end

  // State, datapath registers and strobes registered from the next state,
  // so every strobe is a clean flop output that tracks the state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      ir         <= '0;
      tgt        <= '0;
      pc_read    <= 1'b0;
      pc_write   <= 1'b0;
      pc_incpc   <= 1'b0;
      mem_req    <= 1'b0;
      ir_load    <= 1'b0;
      exec_start <= 1'b0;
      busy       <= 1'b0;
    end else begin
      state_q    <= nxt;
      pc_read    <= (nxt == S_ADDR);
      mem_req    <= (nxt == S_REQ);
      pc_incpc   <= (nxt == S_INC);
      ir_load    <= (nxt == S_INC);
      exec_start <= (nxt == S_EXEC);
      pc_write   <= (nxt == S_BRANCH);
      busy       <= (nxt != S_IDLE) && (nxt != S_FAULT);
      if (state_q == S_REQ && mem_ack)
        ir <= instr_in;
      if (state_q == S_WAIT && exec_done && branch_taken)
        tgt <= branch_target;
    end
  end

`ifdef FETCH_WATCHDOG_EN
  localparam int unsigned CW = $clog2(TIMEOUT) + 1;

  logic [CW-1:0] wd_cnt;

  // Only consulted in REQ; an ack in the timeout cycle takes priority upstream.
  assign wd_expired = (wd_cnt == CW'(TIMEOUT - 1)) && !mem_ack;

  // Count unacknowledged REQ cycles; held at zero outside REQ so each entry starts fresh.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                   wd_cnt <= '0;
    else if (state_q != S_REQ) wd_cnt <= '0;
    else if (!mem_ack)         wd_cnt <= wd_cnt + CW'(1);
  end

  // Fault flag follows the FAULT state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) fault <= 1'b0;
    else     fault <= (nxt == S_FAULT);
  end
`else
  assign wd_expired = 1'b0;
  assign fault      = 1'b0;
`endif

endmodule
